// File: rtl/invoke_argmove.sv
// invoke_argmove: pops argc stack operands into consecutive LVA slots (last-pushed first), with range check.
// Optional ARGMOVE_TIMEOUT_EN adds a watchdog on the stack/LVA handshakes.
module invoke_argmove #(
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 8,
  parameter int LVA_DEPTH = 8,
  parameter int ARGC_W    = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ARGC_W-1:0] argc,
  input  logic [IDX_W-1:0]  base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ARGC_W-1:0] argsmoved,
  output logic              evalpush,
  output logic              evaltrigger,
  input  logic [DATA_W-1:0] evalread,
  input  logic              evaldone,
  output logic              lvaop,
  output logic              lvatrigger,
  output logic [IDX_W-1:0]  lvaindex,
  output logic [DATA_W-1:0] lvawrite,
  input  logic              lvadone
);
  typedef enum logic [2:0] {IDLE, CHECK, POP_REQ, POP_WAIT, WR_REQ, WR_WAIT, FIN} state_t;
  state_t            state;
  logic [ARGC_W-1:0] rem;
  logic [IDX_W-1:0]  base_r;
  logic [IDX_W:0]    span;
  logic              expired;
  if (TIMEOUT < 2 || LVA_DEPTH < 1) begin : g_param_check
    $error("invoke_argmove: TIMEOUT must be >= 2 and LVA_DEPTH >= 1");
  end
  assign evalpush = 1'b0;
  assign span = {1'b0, base_r} + (IDX_W+1)'(rem);
`ifdef ARGMOVE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  assign expired = wait_cnt == CW'(TIMEOUT - 1);
  // Cleared in every non-waiting state, so it restarts at 0 on each entry to a wait state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= '0;
    else wait_cnt <= (state == POP_WAIT || state == WR_WAIT) ? wait_cnt + CW'(1) : '0;
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      rem         <= '0;
      base_r      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      argsmoved   <= '0;
      evaltrigger <= 1'b0;
      lvaop       <= 1'b0;
      lvatrigger  <= 1'b0;
      lvaindex    <= '0;
      lvawrite    <= '0;
    end else begin
      done        <= 1'b0;
      evaltrigger <= 1'b0;
      lvatrigger  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rem       <= argc;
          base_r    <= base;
          argsmoved <= '0;
          err       <= 1'b0;
          busy      <= 1'b1;
          state     <= CHECK;
        end
        CHECK: if (span > (IDX_W+1)'(LVA_DEPTH)) begin
          err   <= 1'b1;
          done  <= 1'b1;
          state <= FIN;
        end else if (rem == '0) begin
          done  <= 1'b1;
          state <= FIN;
        end else begin
          evaltrigger <= 1'b1;
          state       <= POP_REQ;
        end
        POP_REQ: state <= POP_WAIT;
        POP_WAIT: if (evaldone) begin
          lvawrite   <= evalread;
          lvaindex   <= base_r + IDX_W'(rem) - IDX_W'(1);
          lvaop      <= 1'b1;
          lvatrigger <= 1'b1;
          state      <= WR_REQ;
        end else if (expired) begin
          err   <= 1'b1;
          done  <= 1'b1;
          state <= FIN;
        end
        WR_REQ: state <= WR_WAIT;
        WR_WAIT: if (lvadone) begin
          rem         <= rem - ARGC_W'(1);
          argsmoved   <= argsmoved + ARGC_W'(1);
          lvaop       <= 1'b0;
          evaltrigger <= rem != ARGC_W'(1);
          done        <= rem == ARGC_W'(1);
          state       <= (rem != ARGC_W'(1)) ? POP_REQ : FIN;
        end else if (expired) begin
          lvaop <= 1'b0;
          err   <= 1'b1;
          done  <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
